// File: rtl/mux_scan_collector_pkg.sv
// mux_scan_pkg
// Shared types and sizing constants for the 8:1 mux scan collector.
// Contents:
//   scan_state_t - collector FSM states (IDLE, SETTLE, SAMPLE, DONE)
//   NUM_CH       - number of mux channels scanned per request
//   SEL_W        - width of the mux select
//   CNT_W        - width of the settle down-counter
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mux_scan_collector_if.sv
// mux_scan_collector_if
// Bundles the command, mux-side and result handshake signals of the scan
// collector.
//   start, abort    - scan request / cancel (master -> collector)
//   y               - mux output fed back to the collector
//   s0, s1, s2      - registered mux selects (collector -> mux)
//   busy            - scan in progress
//   data_out        - last completed scan, bit k = mux input k
//   out_valid       - result pending
//   out_ready       - downstream accepts the result
// modport slave is the collector, modport master is its environment.
interface mux_scan_collector_if;

    logic       start;
    logic       abort;
    logic       y;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       busy;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output start, abort, y, out_ready,
        input  s0, s1, s2, busy, data_out, out_valid
    );

    modport slave (
        input  start, abort, y, out_ready,
        output s0, s1, s2, busy, data_out, out_valid
    );

endinterface

// File: rtl/mux_scan_settle_timer.sv
// mux_scan_settle_timer
// Loadable down-counter that times the settle window of each mux channel.
//   clk, rst  - clock and asynchronous active-high reset
//   load      - load load_val this cycle (has priority over counting)
//   load_val  - settle length in cycles
//   expired   - high on the last settle cycle (count == 1)
// The counter stops at zero so it never wraps while the FSM is elsewhere.
module mux_scan_settle_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/mux_scan_collector.sv
// mux_scan_collector
// Walks the select lines of an external 8:1 mux through channels 0..7,
// waits SETTLE_CYCLES per channel, samples y once per channel and presents
// the assembled byte with a valid/ready handshake.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - mux_scan_collector_if.slave (start/abort, y, selects, busy,
//              data_out/out_valid/out_ready)
// Parameter SETTLE_CYCLES (0..15): settle cycles per channel before sampling.
module mux_scan_collector
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)
(
    input  logic                 clk,
    input  logic                 rst,
    mux_scan_collector_if.slave  bus
);

    generate
        if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("mux_scan_collector: SETTLE_CYCLES must be in 0..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);

    // With no settle time a channel goes straight to sampling.
    localparam scan_state_t CH_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    scan_state_t        state;
    logic [SEL_W-1:0]   sel;
    logic [NUM_CH-1:0]  shadow;
    logic [NUM_CH-1:0]  data_q;
    logic               valid_q;
    logic               busy_q;
    logic               accept;
    logic               advance;
    logic               timer_expired;

    assign accept  = (state == IDLE) && bus.start && !bus.abort;
    assign advance = (state == SAMPLE) && !bus.abort && (sel != LAST_CH);

    mux_scan_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept || advance),
        .load_val (SETTLE_VAL),
        .expired  (timer_expired)
    );

    // Abort outranks the sample on the same edge; the final sample writes
    // data_out directly from y since shadow[7] is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            shadow  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel    <= '0;
                        shadow <= '0;
                        busy_q <= 1'b1;
                        state  <= CH_ENTRY;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        sel    <= '0;
                        shadow <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (timer_expired) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (bus.abort) begin
                        sel    <= '0;
                        shadow <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        shadow[sel] <= bus.y;
                        if (sel == LAST_CH) begin
                            data_q  <= {bus.y, shadow[NUM_CH-2:0]};
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= DONE;
                        end else begin
                            sel   <= sel + 1'b1;
                            state <= CH_ENTRY;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        sel     <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {bus.s2, bus.s1, bus.s0} = sel;
    assign bus.busy      = busy_q;
    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_collector.sv
// tb_mux_scan_collector
// Self-checking bench for mux_scan_collector. Two instances are built:
// index 0 with SETTLE_CYCLES=0 and index 1 with SETTLE_CYCLES=1, each
// closed around a behavioural 8:1 mux (y = mux_in[{s2,s1,s0}]).
module tb_mux_scan_collector;

    logic clk;
    logic rst;

    logic       start_d [2];
    logic       abort_d [2];
    logic       ready_d [2];
    logic [7:0] mux_in  [2];

    logic [2:0] sel_m   [2];
    logic       busy_m  [2];
    logic       valid_m [2];
    logic [7:0] data_m  [2];

    int vec_count;
    int miscompares;

    mux_scan_collector_if bus_s0 ();
    mux_scan_collector_if bus_s1 ();

    mux_scan_collector #(.SETTLE_CYCLES(0)) dut_s0 (
        .clk (clk),
        .rst (rst),
        .bus (bus_s0.slave)
    );

    mux_scan_collector #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_s1.slave)
    );

    // Behavioural 8:1 muxes and stimulus/monitor wiring.
    assign bus_s0.start     = start_d[0];
    assign bus_s0.abort     = abort_d[0];
    assign bus_s0.out_ready = ready_d[0];
    assign bus_s0.y         = mux_in[0][{bus_s0.s2, bus_s0.s1, bus_s0.s0}];
    assign bus_s1.start     = start_d[1];
    assign bus_s1.abort     = abort_d[1];
    assign bus_s1.out_ready = ready_d[1];
    assign bus_s1.y         = mux_in[1][{bus_s1.s2, bus_s1.s1, bus_s1.s0}];

    assign sel_m[0]   = {bus_s0.s2, bus_s0.s1, bus_s0.s0};
    assign sel_m[1]   = {bus_s1.s2, bus_s1.s1, bus_s1.s0};
    assign busy_m[0]  = bus_s0.busy;
    assign busy_m[1]  = bus_s1.busy;
    assign valid_m[0] = bus_s0.out_valid;
    assign valid_m[1] = bus_s1.out_valid;
    assign data_m[0]  = bus_s0.data_out;
    assign data_m[1]  = bus_s1.data_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        int         settle;
        logic [7:0] pattern;
        logic [7:0] expected;
    } scan_vec_t;

    scan_vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start on instance d and follows the scan to completion,
    // checking the select walk, busy, result timing and result value.
    task automatic applyStimulus(input int d, input int settle,
                                 input logic [7:0] expected);
        int  lat;
        bit  walk_ok;
        bit  early;
        lat     = 8 * (settle + 1);
        walk_ok = 1'b1;
        early   = 1'b0;
        start_d[d] = 1'b1;
        tick();
        start_d[d] = 1'b0;
        for (int k = 0; k < lat; k++) begin
            if (sel_m[d] != 3'(k / (settle + 1)) || busy_m[d] !== 1'b1)
                walk_ok = 1'b0;
            if (valid_m[d] !== 1'b0)
                early = 1'b1;
            tick();
        end
        checkOutput("select_walk", 32'(walk_ok), 32'd1);
        checkOutput("no_early_valid", 32'(early), 32'd0);
        checkOutput("valid_at_latency", 32'(valid_m[d]), 32'd1);
        checkOutput("scan_data", 32'(data_m[d]), 32'(expected));
        checkOutput("busy_low_done", 32'(busy_m[d]), 32'd0);
        checkOutput("sel_held_7", 32'(sel_m[d]), 32'd7);
    endtask

    task automatic release_result(input int d);
        ready_d[d] = 1'b1;
        tick();
        ready_d[d] = 1'b0;
        checkOutput("valid_cleared", 32'(valid_m[d]), 32'd0);
        checkOutput("sel_back_to_0", 32'(sel_m[d]), 32'd0);
    endtask

    initial begin
        bit held_ok;
        vec_count   = 0;
        miscompares = 0;
        for (int d = 0; d < 2; d++) begin
            start_d[d] = 1'b0;
            abort_d[d] = 1'b0;
            ready_d[d] = 1'b0;
            mux_in[d]  = 8'h00;
        end

        vecs[0] = '{1, 1, 8'hA6, 8'hA6};
        vecs[1] = '{1, 1, 8'h5A, 8'h5A};
        vecs[2] = '{1, 1, 8'h81, 8'h81};
        vecs[3] = '{0, 0, 8'hFF, 8'hFF};
        vecs[4] = '{0, 0, 8'h00, 8'h00};
        vecs[5] = '{0, 0, 8'hC3, 8'hC3};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_sel", 32'(sel_m[d]), 32'd0);
            checkOutput("reset_busy", 32'(busy_m[d]), 32'd0);
            checkOutput("reset_valid", 32'(valid_m[d]), 32'd0);
            checkOutput("reset_data", 32'(data_m[d]), 32'd0);
        end
        rst = 1'b0;
        tick();

        // Table-driven full scans on both settle settings
        for (int v = 0; v < 6; v++) begin
            mux_in[vecs[v].dut] = vecs[v].pattern;
            applyStimulus(vecs[v].dut, vecs[v].settle, vecs[v].expected);
            release_result(vecs[v].dut);
        end

        // SETTLE_CYCLES=0, out_ready tied high, back-to-back scans
        ready_d[0] = 1'b1;
        mux_in[0]  = 8'hFF;
        applyStimulus(0, 0, 8'hFF);
        mux_in[0]  = 8'h00;
        tick();
        checkOutput("b2b_valid_one_cycle_a", 32'(valid_m[0]), 32'd0);
        applyStimulus(0, 0, 8'h00);
        tick();
        checkOutput("b2b_valid_one_cycle_b", 32'(valid_m[0]), 32'd0);
        ready_d[0] = 1'b0;

        // Result held while out_ready low; start pulses ignored in DONE
        mux_in[1] = 8'h3C;
        applyStimulus(1, 1, 8'h3C);
        held_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            start_d[1] = (c % 2 == 0);
            tick();
            if (valid_m[1] !== 1'b1 || data_m[1] !== 8'h3C ||
                sel_m[1] !== 3'd7 || busy_m[1] !== 1'b0)
                held_ok = 1'b0;
        end
        checkOutput("done_hold", 32'(held_ok), 32'd1);
        start_d[1] = 1'b1;
        ready_d[1] = 1'b1;
        tick();
        start_d[1] = 1'b0;
        ready_d[1] = 1'b0;
        checkOutput("done_exit_valid", 32'(valid_m[1]), 32'd0);
        checkOutput("done_exit_busy", 32'(busy_m[1]), 32'd0);
        tick();
        checkOutput("start_ignored_in_done", 32'(busy_m[1]), 32'd0);

        // Abort on the 5th cycle of a scan keeps the previous result
        mux_in[1]  = 8'hFF;
        start_d[1] = 1'b1;
        tick();
        start_d[1] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        abort_d[1] = 1'b1;
        tick();
        abort_d[1] = 1'b0;
        checkOutput("abort_sel", 32'(sel_m[1]), 32'd0);
        checkOutput("abort_busy", 32'(busy_m[1]), 32'd0);
        held_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (valid_m[1] !== 1'b0 || data_m[1] !== 8'h3C || busy_m[1] !== 1'b0)
                held_ok = 1'b0;
        end
        checkOutput("abort_no_result", 32'(held_ok), 32'd1);

        // Abort on the final sample edge outranks the completion
        start_d[1] = 1'b1;
        tick();
        start_d[1] = 1'b0;
        for (int c = 0; c < 15; c++) tick();
        checkOutput("pre_final_sel", 32'(sel_m[1]), 32'd7);
        abort_d[1] = 1'b1;
        tick();
        abort_d[1] = 1'b0;
        checkOutput("abort_final_valid", 32'(valid_m[1]), 32'd0);
        checkOutput("abort_final_data", 32'(data_m[1]), 32'h3C);
        checkOutput("abort_final_sel", 32'(sel_m[1]), 32'd0);

        // Asynchronous reset between edges mid-scan
        mux_in[1]  = 8'h96;
        start_d[1] = 1'b1;
        tick();
        start_d[1] = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_sel", 32'(sel_m[1]), 32'd0);
        checkOutput("async_rst_busy", 32'(busy_m[1]), 32'd0);
        checkOutput("async_rst_valid", 32'(valid_m[1]), 32'd0);
        checkOutput("async_rst_data", 32'(data_m[1]), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        mux_in[1] = 8'hA6;
        applyStimulus(1, 1, 8'hA6);
        release_result(1);

        // start together with abort in IDLE is not accepted
        start_d[1] = 1'b1;
        abort_d[1] = 1'b1;
        tick();
        start_d[1] = 1'b0;
        abort_d[1] = 1'b0;
        checkOutput("start_abort_busy", 32'(busy_m[1]), 32'd0);
        mux_in[1] = 8'h69;
        applyStimulus(1, 1, 8'h69);
        release_result(1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
